// File: rtl/mmio_sim_pkg.sv
// Shared constants for the simulation-control MMIO peripheral: register offsets,
// done_code values and the controller state encoding.
package mmio_sim_pkg;

   localparam logic [31:0] PUTC_OFS    = 32'h1C;
   localparam logic [31:0] CHAN_STRIDE = 32'h100;
   localparam logic [31:0] EXIT_OFS    = 32'h2C;
   localparam logic [31:0] STATUS_OFS  = 32'h30;

   localparam logic [1:0] DONE_EXIT    = 2'd0;
   localparam logic [1:0] DONE_TIMEOUT = 2'd1;
   localparam logic [1:0] DONE_RANGE   = 2'd2;
   localparam logic [1:0] DONE_EXC     = 2'd3;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Registers are decoded on the 32-bit word address.
   function automatic logic [29:0] word_of(input logic [31:0] byte_addr);
      return byte_addr[31:2];
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide FIFO with first-word fall-through read; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     resetb,
   input  logic                     push,
   input  logic [7:0]               wdata,
   input  logic                     pop,
   output logic [7:0]               rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   level_q;
   logic          push_ok;
   logic          pop_ok;

   assign empty   = (level_q == '0);
   assign full    = (level_q == (AW+1)'(DEPTH));
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign rdata   = mem_q[rd_ptr_q];
   assign level   = level_q;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         level_q <= level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
   end

endmodule

// File: rtl/mmio_sim_ctrl.sv
// Simulation-control peripheral: console FIFOs with round-robin drain, EXIT/drain
// sequencing, watchdog and range checks. Optional STATUS read port: MMIO_STATUS_EN.
module mmio_sim_ctrl
   import mmio_sim_pkg::*;
#(
   parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
   parameter int          NCHAN      = 2,
   parameter int          FIFO_DEPTH = 16,
   parameter int          IRAMSIZE   = 128*1024,
   parameter int          DRAMSIZE   = 128*1024,
   parameter int          WDOG_LIMIT = 100,
   localparam int         CW         = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
   input  logic              clk,
   input  logic              resetb,
   input  logic              stall,
   input  logic              exception,
   input  logic [31:0]       if_pc,
   input  logic              imem_ready,
   input  logic [31:0]       imem_addr,
   input  logic              dmem_wready,
   input  logic [31:0]       dmem_waddr,
   input  logic [31:0]       dmem_wdata,
   input  logic [3:0]        dmem_wstrb,
   output logic              ch_valid,
   input  logic              ch_ready,
   output logic [7:0]        ch_data,
   output logic [CW-1:0]     ch_chan,
   output logic              done,
   output logic [1:0]        done_code,
   output logic [31:0]       done_value,
   output logic [NCHAN-1:0]  ovf
`ifdef MMIO_STATUS_EN
   ,
   input  logic              dmem_rready,
   input  logic [31:0]       dmem_raddr,
   output logic [31:0]       mmio_rdata
`endif
);

   localparam int          LW       = $clog2(FIFO_DEPTH) + 1;
   localparam int          IW       = $clog2(IRAMSIZE);
   localparam logic [32:0] MEM_TOP  = 33'(IRAMSIZE) + 33'(DRAMSIZE);
   localparam logic [32:0] WIN_LO   = {1'b0, MMIO_BASE};
   localparam logic [32:0] WIN_HI   = WIN_LO + 33'(CHAN_STRIDE) * 33'(NCHAN);
   localparam logic [15:0] WDOG_LIM = 16'(WDOG_LIMIT);
   localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
   localparam logic [29:0] EXIT_W   = word_of(MMIO_BASE + EXIT_OFS);
   localparam logic [29:0] STATUS_W = word_of(MMIO_BASE + STATUS_OFS);

   state_e              state_q, state_d;
   logic                done_q, done_d;
   logic [1:0]          code_q, code_d;
   logic [31:0]         value_q, value_d;
   logic                ch_valid_q, ch_valid_d;
   logic [7:0]          ch_data_q, ch_data_d;
   logic [CW-1:0]       ch_chan_q, ch_chan_d;
   logic [CW-1:0]       last_q, last_d;
   logic [NCHAN-1:0]    ovf_q, ovf_d;
   logic [15:0]         wdog_q, wdog_d;
   logic [31:0]         pc_q;

   logic                active;
   logic                wr_en;
   logic                xfer;
   logic                load_ok;
   logic                exit_wr;
   logic                ovf_clear;
   logic                imem_bad;
   logic                dmem_bad;
   logic                in_win;
   logic                timeout;
   logic                grant_found;
   logic [CW-1:0]       grant_idx;
   logic [CW:0]         rr_sum;

   logic [NCHAN-1:0]          putc_hit;
   logic [NCHAN-1:0]          held;
   logic [NCHAN-1:0]          push;
   logic [NCHAN-1:0]          pop;
   logic [NCHAN-1:0]          drop;
   logic [NCHAN-1:0]          fifo_empty;
   logic [NCHAN-1:0]          fifo_full;
   logic [NCHAN-1:0][7:0]     fifo_rdata;
   logic [NCHAN-1:0][LW-1:0]  fifo_level;
   logic [LW-1:0]             occ [NCHAN];

   assign active  = (state_q != DONE);
   assign wr_en   = dmem_wready && active;
   assign xfer    = ch_valid_q && ch_ready && active;
   assign load_ok = active && (!ch_valid_q || ch_ready) && grant_found;
   assign exit_wr = wr_en && (dmem_waddr[31:2] == EXIT_W);

   // Occupancy counts the byte parked in the output register, so each channel
   // holds FIFO_DEPTH bytes in total and a transfer frees a slot for a same-cycle push.
   generate
      for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
         assign putc_hit[gi] = (dmem_waddr[31:2] ==
                                word_of(MMIO_BASE + PUTC_OFS + CHAN_STRIDE * 32'(gi)));
         assign held[gi]     = ch_valid_q && (ch_chan_q == CW'(gi));
         assign occ[gi]      = fifo_level[gi] + LW'(held[gi]);
         assign push[gi]     = wr_en && putc_hit[gi] && dmem_wstrb[0] &&
                               ((occ[gi] != DEPTH_L) || (xfer && held[gi]));
         assign drop[gi]     = wr_en && putc_hit[gi] && dmem_wstrb[0] && !push[gi];
         assign pop[gi]      = load_ok && (grant_idx == CW'(gi));

         byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk    (clk),
            .resetb (resetb),
            .push   (push[gi]),
            .wdata  (dmem_wdata[7:0]),
            .pop    (pop[gi]),
            .rdata  (fifo_rdata[gi]),
            .full   (fifo_full[gi]),
            .empty  (fifo_empty[gi]),
            .level  (fifo_level[gi])
         );
      end
   endgenerate

   // Round-robin search starting one past the last granted channel.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      rr_sum      = '0;
      for (int i = 1; i <= NCHAN; i++) begin
         rr_sum = {1'b0, last_q} + (CW+1)'(i);
         if (rr_sum >= (CW+1)'(NCHAN)) begin
            rr_sum = rr_sum - (CW+1)'(NCHAN);
         end
         if (!grant_found && !fifo_empty[rr_sum[CW-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = rr_sum[CW-1:0];
         end
      end
   end

   always_comb begin
      ch_valid_d = ch_valid_q;
      ch_data_d  = ch_data_q;
      ch_chan_d  = ch_chan_q;
      last_d     = last_q;
      if (load_ok) begin
         ch_valid_d = 1'b1;
         ch_data_d  = fifo_rdata[grant_idx];
         ch_chan_d  = grant_idx;
         last_d     = grant_idx;
      end else if (xfer) begin
         ch_valid_d = 1'b0;
      end
   end

   always_comb begin
      ovf_d = ovf_q;
      if (ovf_clear) begin
         ovf_d = '0;
      end
      ovf_d = ovf_d | drop;
   end

   always_comb begin
      wdog_d = wdog_q;
      if (if_pc != pc_q) begin
         wdog_d = '0;
      end else if (!stall && (wdog_q != 16'hFFFF)) begin
         wdog_d = wdog_q + 16'd1;
      end
   end

   assign imem_bad = imem_ready && (|(imem_addr >> IW));
   assign in_win   = ({1'b0, dmem_waddr} >= WIN_LO) && ({1'b0, dmem_waddr} < WIN_HI);
   assign dmem_bad = dmem_wready && ({1'b0, dmem_waddr} >= MEM_TOP) && !in_win;
   assign timeout  = (wdog_q > WDOG_LIM);

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      value_d = value_q;
      if (active) begin
         if (exception) begin
            state_d = DONE;
            code_d  = DONE_EXC;
         end else if (imem_bad) begin
            state_d = DONE;
            code_d  = DONE_RANGE;
            value_d = imem_addr;
         end else if (dmem_bad) begin
            state_d = DONE;
            code_d  = DONE_RANGE;
            value_d = dmem_waddr;
         end else if (timeout) begin
            state_d = DONE;
            code_d  = DONE_TIMEOUT;
            value_d = if_pc;
         end else if ((state_q == RUN) && exit_wr) begin
            state_d = DRAIN;
            value_d = dmem_wdata;
         end else if ((state_q == DRAIN) && (&fifo_empty) && !ch_valid_q && !(|push)) begin
            state_d = DONE;
            code_d  = DONE_EXIT;
         end
      end
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q    <= RUN;
         done_q     <= 1'b0;
         code_q     <= '0;
         value_q    <= '0;
         ch_valid_q <= 1'b0;
         ch_data_q  <= '0;
         ch_chan_q  <= '0;
         last_q     <= '0;
         ovf_q      <= '0;
         wdog_q     <= '0;
         pc_q       <= '0;
      end else begin
         state_q    <= state_d;
         done_q     <= done_d;
         code_q     <= code_d;
         value_q    <= value_d;
         ch_valid_q <= ch_valid_d;
         ch_data_q  <= ch_data_d;
         ch_chan_q  <= ch_chan_d;
         last_q     <= last_d;
         ovf_q      <= ovf_d;
         wdog_q     <= wdog_d;
         pc_q       <= if_pc;
      end
   end

`ifdef MMIO_STATUS_EN
   logic [31:0] rdata_q;
   logic        unused_raddr;

   assign ovf_clear    = wr_en && (dmem_waddr[31:2] == STATUS_W) && dmem_wdata[0];
   assign mmio_rdata   = rdata_q;
   assign unused_raddr = ^dmem_raddr[1:0];

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         rdata_q <= '0;
      end else if (dmem_rready && (dmem_raddr[31:2] == STATUS_W)) begin
         rdata_q <= {8'(ovf_q), 8'h00, 8'(occ[0]), 8'(state_q)};
      end else begin
         rdata_q <= '0;
      end
   end
`else
   assign ovf_clear = 1'b0;
`endif

   logic unused_sig;
   assign unused_sig = ^{imem_addr[IW-1:0], dmem_wstrb[3:1], fifo_full};

   assign ch_valid   = ch_valid_q;
   assign ch_data    = ch_data_q;
   assign ch_chan    = ch_chan_q;
   assign done       = done_q;
   assign done_code  = code_q;
   assign done_value = value_q;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_mmio_sim_ctrl.sv
// Self-checking bench for mmio_sim_ctrl: console bytes are tracked in a scoreboard
// queue filled at write time and popped on each ch_valid&&ch_ready transfer.
module tb_mmio_sim_ctrl;

   localparam logic [31:0] PUTC0 = 32'h8000_001C;
   localparam logic [31:0] PUTC1 = 32'h8000_011C;
   localparam logic [31:0] EXITA = 32'h8000_002C;

   logic        clk = 1'b0;
   logic        resetb = 1'b0;
   logic        stall = 1'b1;
   logic        exception = 1'b0;
   logic [31:0] if_pc = '0;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_addr = '0;
   logic        dmem_wready = 1'b0;
   logic [31:0] dmem_waddr = '0;
   logic [31:0] dmem_wdata = '0;
   logic [3:0]  dmem_wstrb = '0;
   logic        ch_valid;
   logic        ch_ready = 1'b0;
   logic [7:0]  ch_data;
   logic [0:0]  ch_chan;
   logic        done;
   logic [1:0]  done_code;
   logic [31:0] done_value;
   logic [1:0]  ovf;
`ifdef MMIO_STATUS_EN
   logic        dmem_rready = 1'b0;
   logic [31:0] dmem_raddr = '0;
   logic [31:0] mmio_rdata;
`endif

   int total = 0;
   int bad = 0;
   logic [15:0] sb[$];

   always #5 clk = ~clk;

   mmio_sim_ctrl dut (
      .clk         (clk),
      .resetb      (resetb),
      .stall       (stall),
      .exception   (exception),
      .if_pc       (if_pc),
      .imem_ready  (imem_ready),
      .imem_addr   (imem_addr),
      .dmem_wready (dmem_wready),
      .dmem_waddr  (dmem_waddr),
      .dmem_wdata  (dmem_wdata),
      .dmem_wstrb  (dmem_wstrb),
      .ch_valid    (ch_valid),
      .ch_ready    (ch_ready),
      .ch_data     (ch_data),
      .ch_chan     (ch_chan),
      .done        (done),
      .done_code   (done_code),
      .done_value  (done_value),
      .ovf         (ovf)
`ifdef MMIO_STATUS_EN
      ,
      .dmem_rready (dmem_rready),
      .dmem_raddr  (dmem_raddr),
      .mmio_rdata  (mmio_rdata)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      dmem_wready = 1'b1;
      dmem_waddr  = a;
      dmem_wdata  = d;
      dmem_wstrb  = 4'hF;
      tick();
      dmem_wready = 1'b0;
      dmem_wstrb  = 4'h0;
   endtask

   task automatic do_reset();
      resetb     = 1'b0;
      ch_ready   = 1'b0;
      stall      = 1'b1;
      exception  = 1'b0;
      if_pc      = '0;
      imem_ready = 1'b0;
      imem_addr  = '0;
      sb.delete();
      tick();
      resetb = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      int n;
      resetb = 1'b0;
      #3;
      total++; if (ch_valid !== 1'b0) begin bad++; $display("FAIL rst_ch_valid: got %b want 0", ch_valid); end
      total++; if (ch_data !== 8'h00) begin bad++; $display("FAIL rst_ch_data: got %h want 00", ch_data); end
      total++; if (ch_chan !== 1'b0) begin bad++; $display("FAIL rst_ch_chan: got %h want 0", ch_chan); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
      total++; if (done_code !== 2'd0) begin bad++; $display("FAIL rst_code: got %0d want 0", done_code); end
      total++; if (done_value !== 32'h0) begin bad++; $display("FAIL rst_value: got %h want 0", done_value); end
      total++; if (ovf !== 2'b00) begin bad++; $display("FAIL rst_ovf: got %b want 00", ovf); end
      tick();
      resetb = 1'b1;
      tick();
      wr(PUTC0, 32'h77);
      tick();
      total++; if (ch_valid !== 1'b1) begin bad++; $display("FAIL pre_rst_valid: got %b want 1", ch_valid); end
      resetb = 1'b0;
      #2;
      total++; if ({ch_valid, ch_data} !== 9'h000) begin bad++; $display("FAIL async_rst: got valid/data %h want 000", {ch_valid, ch_data}); end
      tick();
      resetb   = 1'b1;
      ch_ready = 1'b1;
      n = 0;
      repeat (6) begin
         tick();
         if (ch_valid) n++;
      end
      total++; if (n != 0) begin bad++; $display("FAIL rst_fifo_lost: got %0d valid cycles want 0", n); end
      $display("test_reset done");
   endtask

   task automatic test_putc();
      int cyc;
      int n;
      logic [15:0] e;
      do_reset();
      ch_ready = 1'b1;
      sb.push_back({8'd0, 8'h41});
      wr(PUTC0, 32'h41);
      sb.push_back({8'd0, 8'h42});
      wr(PUTC0, 32'h42);
      cyc = 0;
      n = 0;
      while (sb.size() > 0 && cyc < 20) begin
         if (ch_valid && ch_ready) begin
            e = sb.pop_front();
            n++;
            total++;
            if ({8'(ch_chan), ch_data} !== e) begin bad++; $display("FAIL putc_byte: got %h want %h", {8'(ch_chan), ch_data}, e); end
         end
         tick();
         cyc++;
      end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL putc_timeout: got %0d left want 0", sb.size()); end
      repeat (5) begin
         if (ch_valid) n++;
         tick();
      end
      total++; if (n != 2) begin bad++; $display("FAIL putc_count: got %0d want 2", n); end
      total++; if (ovf !== 2'b00) begin bad++; $display("FAIL putc_ovf: got %b want 00", ovf); end
      $display("test_putc done: %0d bytes", n);
   endtask

   task automatic test_overflow();
      int cyc;
      int n;
      logic [15:0] e;
      do_reset();
      ch_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         if (i < 16) sb.push_back({8'd1, 8'(8'h60 + i)});
         wr(PUTC1, 32'(8'h60 + i));
      end
      tick();
      total++; if (ovf !== 2'b10) begin bad++; $display("FAIL ovf_flag: got %b want 10", ovf); end
      ch_ready = 1'b1;
      cyc = 0;
      n = 0;
      while (sb.size() > 0 && cyc < 40) begin
         if (ch_valid && ch_ready) begin
            e = sb.pop_front();
            n++;
            total++;
            if ({8'(ch_chan), ch_data} !== e) begin bad++; $display("FAIL ovf_byte: got %h want %h", {8'(ch_chan), ch_data}, e); end
         end
         tick();
         cyc++;
      end
      total++; if (cyc != 16) begin bad++; $display("FAIL ovf_throughput: got %0d cycles want 16", cyc); end
      repeat (4) begin
         if (ch_valid) n++;
         tick();
      end
      total++; if (n != 16) begin bad++; $display("FAIL ovf_count: got %0d want 16", n); end
      $display("test_overflow done: %0d bytes", n);
   endtask

   task automatic test_back_to_back();
      int cyc;
      logic [15:0] e;
      do_reset();
      ch_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         sb.push_back({8'(i % 2), 8'(8'hA0 + i)});
         wr(((i % 2) == 0) ? PUTC0 : PUTC1, 32'(8'hA0 + i));
      end
      ch_ready = 1'b1;
      cyc = 0;
      while (sb.size() > 0 && cyc < 30) begin
         if (ch_valid && ch_ready) begin
            e = sb.pop_front();
            total++;
            if ({8'(ch_chan), ch_data} !== e) begin bad++; $display("FAIL rr_byte: got %h want %h", {8'(ch_chan), ch_data}, e); end
         end
         tick();
         cyc++;
      end
      total++; if (cyc != 6) begin bad++; $display("FAIL rr_throughput: got %0d cycles want 6", cyc); end
      $display("test_back_to_back done: %0d cycles", cyc);
   endtask

   task automatic test_exit_drain();
      int cyc;
      logic [15:0] e;
      do_reset();
      ch_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sb.push_back({8'd0, 8'(8'h31 + i)});
         wr(PUTC0, 32'(8'h31 + i));
      end
      wr(EXITA, 32'h5);
      repeat (4) tick();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL exit_early_done: got %b want 0", done); end
      ch_ready = 1'b1;
      cyc = 0;
      while (sb.size() > 0 && cyc < 20) begin
         if (ch_valid && ch_ready) begin
            e = sb.pop_front();
            total++;
            if ({8'(ch_chan), ch_data} !== e) begin bad++; $display("FAIL exit_byte: got %h want %h", {8'(ch_chan), ch_data}, e); end
         end
         tick();
         cyc++;
      end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL exit_done_at_last: got %b want 0", done); end
      cyc = 0;
      while (!done && cyc < 10) begin
         tick();
         cyc++;
      end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL exit_done: got %b want 1", done); end
      total++; if (done_code !== 2'd0) begin bad++; $display("FAIL exit_code: got %0d want 0", done_code); end
      total++; if (done_value !== 32'h5) begin bad++; $display("FAIL exit_value: got %h want 5", done_value); end
      wr(EXITA, 32'h9);
      exception = 1'b1;
      tick();
      exception = 1'b0;
      total++; if ({done, done_code, done_value} !== {1'b1, 2'd0, 32'h5}) begin
         bad++; $display("FAIL done_frozen: got %b/%0d/%h want 1/0/00000005", done, done_code, done_value);
      end
      $display("test_exit_drain done");
   endtask

   task automatic test_watchdog();
      int cyc;
      do_reset();
      resetb = 1'b0;
      if_pc  = 32'h100;
      stall  = 1'b0;
      tick();
      resetb = 1'b1;
      repeat (100) tick();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL wdog_early: got %b want 0", done); end
      cyc = 0;
      while (!done && cyc < 20) begin
         tick();
         cyc++;
      end
      total++; if (cyc != 3) begin bad++; $display("FAIL wdog_latency: got %0d extra cycles want 3", cyc); end
      total++; if (done_code !== 2'd1) begin bad++; $display("FAIL wdog_code: got %0d want 1", done_code); end
      total++; if (done_value !== 32'h100) begin bad++; $display("FAIL wdog_value: got %h want 00000100", done_value); end
      resetb = 1'b0;
      stall  = 1'b1;
      tick();
      resetb = 1'b1;
      repeat (300) tick();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL wdog_stall: got %b want 0", done); end
      $display("test_watchdog done");
   endtask

   task automatic test_range();
      do_reset();
      exception   = 1'b1;
      wr(32'h0004_0000, 32'h0);
      exception   = 1'b0;
      total++; if ({done, done_code} !== 3'b111) begin bad++; $display("FAIL exc_prio: got %b/%0d want 1/3", done, done_code); end
      do_reset();
      wr(32'h0004_0000, 32'h1234);
      total++; if ({done, done_code} !== 3'b110) begin bad++; $display("FAIL range_code: got %b/%0d want 1/2", done, done_code); end
      total++; if (done_value !== 32'h0004_0000) begin bad++; $display("FAIL range_value: got %h want 00040000", done_value); end
      do_reset();
      wr(32'h0003_FFFC, 32'h1);
      wr(32'h8000_0004, 32'h1);
      wr(32'h8000_01FC, 32'h1);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL range_inside: got %b want 0", done); end
      wr(32'h8000_0200, 32'h1);
      total++; if ({done, done_code, done_value} !== {1'b1, 2'd2, 32'h8000_0200}) begin
         bad++; $display("FAIL window_edge: got %b/%0d/%h want 1/2/80000200", done, done_code, done_value);
      end
      do_reset();
      imem_ready = 1'b1;
      imem_addr  = 32'h0002_0000;
      wr(EXITA, 32'h7);
      imem_ready = 1'b0;
      total++; if ({done, done_code, done_value} !== {1'b1, 2'd2, 32'h0002_0000}) begin
         bad++; $display("FAIL fatal_over_exit: got %b/%0d/%h want 1/2/00020000", done, done_code, done_value);
      end
      $display("test_range done");
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      tick();
      test_reset();
      test_putc();
      test_overflow();
      test_back_to_back();
      test_exit_drain();
      test_watchdog();
      test_range();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
